spi_cfg_regbank: RTL and testbench
==================================

Name: spi_cfg_regbank

Overview:
- Parametrised SPI-programmable configuration register bank.
- Replaces the fixed one-byte command decoder with addressed write/read transactions over N 8-bit registers, burst auto-increment, and MISO readback.
- Host writes land in a shadow copy. The active copy, which drives the video pipeline (Sobel threshold, channel select, etc.), updates only on a vsync rising edge, so settings never change mid-frame.

Parameters:
- NUM_REGS, 8, number of 8-bit registers (2..128).
- ADDR_W, 7, command address field width (fixed by protocol; localparam in package).
- RST_VALS, {NUM_REGS-1{8'h00}, 8'd50}, packed reset value per register; reg0 = threshold 50.

Ports:
- sclk  in  1  system clock; the only clock.
- s_rst_n  in  1  asynchronous active-low reset.
- spi_cs  in  1  SPI chip select, active low, asynchronous to sclk.
- spi_sck  in  1  SPI clock, mode 0, asynchronous; frequency ≤ sclk/8.
- spi_mosi  in  1  SPI data in, MSB first.
- vsync  in  1  frame sync, asynchronous; rising edge = frame boundary.
- spi_miso  out  1  SPI data out, MSB first.
- cfg_regs  out  NUM_REGS*8  active register values; reg i at [8i+7:8i].
- cfg_update  out  1  one-cycle pulse when active copy reloads.
- cfg_err  out  1  sticky flag: an out-of-range address was accessed.

Behaviour:
- Reset (async, s_rst_n low):
  - shadow = active = RST_VALS.
  - spi_miso = 0, cfg_update = 0, cfg_err = 0.
  - FSM = IDLE; all synchronisers and shift registers cleared.
- Input synchronisation: spi_cs, spi_sck, spi_mosi and vsync each pass through 2-flop synchronisers in sclk. SCK rise/fall and vsync rise are detected from a third registered stage.
- Byte reception: on each synchronised SCK rise with CS low, shift MOSI in and increment bit_cnt. After the 8th rise, byte_done pulses for one cycle with the byte.
- Command byte: bit7 = 1 write / 0 read; bits6:0 = address.
- FSM:
  - IDLE -> CMD on CS fall.
  - CMD -> DATA on byte_done (latch rw, addr).
  - DATA -> DATA on byte_done: perform access, then addr += 1.
  - Any state -> IDLE on CS high. Partial byte discarded; bit_cnt cleared.
- Write: on a DATA byte_done with addr < NUM_REGS, shadow[addr] <= byte in the following cycle.
- Read (MISO):
  - At CMD or DATA byte_done, load tx_shift with shadow[addr_next], or 8'h00 if out of range.
  - spi_miso = tx_shift[7].
  - Shift left on each SCK fall while bit_cnt ≠ 0.
  - spi_miso = 0 when CS high.
  - Write transactions also shift shadow data out; the host ignores it.
- Out of range: addr ≥ NUM_REGS → writes are dropped, reads return 0x00, and cfg_err sets. cfg_err clears only on reset.
- Address wrap: after 127, addr wraps to 0 within a burst.
- Frame update: on a synchronised vsync rise, active <= shadow (all registers at once) and cfg_update pulses 1 cycle.
  - Latency: vsync pin edge to cfg_regs change is 3 sclk cycles.
- Write and vsync rise in the same cycle: active takes the pre-write shadow; the new value appears at the next vsync.
- vsync held high: a single update per rising edge only.

Optional Feature:
- Macro: CFG_IMMEDIATE_EN.
- Defined: no shadow stage. Writes go directly to active in the same cycle as the shadow write would occur, and cfg_update pulses on each committed write. vsync is ignored (synchroniser removed). Readback returns active.
- Undefined: frame-synchronous shadow/active behaviour as above.

Decomposition:
- Package cfg_regbank_pkg:
  - localparams CMD_WR_BIT = 7, ADDR_W = 7.
  - FSM state encodings IDLE/CMD/DATA.
  - Default threshold constant 8'd50.
- One sub-module, spi_byte_rx_sync: synchronisers, SCK edge detection, RX shift/bit_cnt, byte_done, and the TX shift register with load port. The top holds the FSM, shadow/active arrays and vsync logic.

Test Plan:
- Reset only → cfg_regs[7:0] = 50, other registers 0, spi_miso = 0, cfg_err = 0.
- Write 0x81,0x3C (reg1 = 0x3C), then vsync pulse → cfg_regs[15:8] stays 0 before vsync, becomes 0x3C three cycles after the vsync rise; cfg_update is high for exactly 1 cycle.
- Burst write 0x80,0x14,0x01,0x1E (reg0 = 20, reg1 = 1, reg2 = 30), then read 0x00 + 3 dummy bytes → MISO returns 0x14,0x01,0x1E.
- Write 0x8A,0xFF (address 10 ≥ 8) → no register changes, cfg_err = 1; reading 0x0A returns 0x00.
- CS raised after 4 bits of a data byte → no write occurs, FSM back in IDLE; the next full transaction completes correctly.
- Write data byte_done in the same cycle as the vsync rise → active keeps the old value; the new value appears at the next vsync.

Source files
------------

// File: rtl/spi_cfg_regbank_pkg.sv
// Shared constants for the SPI configuration register bank.
//   CMD_WR_BIT  : command byte bit selecting write (1) or read (0)
//   ADDR_W      : command address field width
//   DEF_THRESH  : power-on Sobel threshold held in register 0
//   ST_*        : control FSM state encodings
package cfg_regbank_pkg;

  localparam int unsigned CMD_WR_BIT = 7;
  localparam int unsigned ADDR_W     = 7;

  localparam logic [7:0] DEF_THRESH = 8'd50;

  typedef logic [1:0] fsm_state_t;

  localparam fsm_state_t ST_IDLE = 2'd0;
  localparam fsm_state_t ST_CMD  = 2'd1;
  localparam fsm_state_t ST_DATA = 2'd2;

endpackage

// File: rtl/spi_cfg_regbank_if.sv
// SPI pin bundle for the configuration register bank.
//   spi_cs   : chip select, active low
//   spi_sck  : SPI clock, mode 0
//   spi_mosi : host-to-device data, MSB first
//   spi_miso : device-to-host data, MSB first
// master drives cs/sck/mosi; slave drives miso.
interface spi_cfg_regbank_if;
  logic spi_cs;
  logic spi_sck;
  logic spi_mosi;
  logic spi_miso;

  modport master (output spi_cs, output spi_sck, output spi_mosi, input spi_miso);
  modport slave  (input spi_cs, input spi_sck, input spi_mosi, output spi_miso);
endinterface

// File: rtl/spi_cfg_regbank_rx_sync.sv
// SPI front end in the sclk domain: pin synchronisers, SCK edge detection,
// receive shifter with byte strobe, and the MISO transmit shifter.
//   sclk, s_rst_n     : system clock, async active-low reset
//   spi_cs/sck/mosi   : raw asynchronous SPI pins
//   tx_load, tx_data  : load the transmit shifter (priority over shifting)
//   cs_active         : synchronised chip select asserted
//   cs_fall           : one-cycle strobe on chip select assertion
//   byte_done, rx_byte: one-cycle strobe with the completed received byte
//   spi_miso          : transmit shifter MSB, forced low while deselected
module spi_byte_rx_sync (
  input  logic       sclk,
  input  logic       s_rst_n,
  input  logic       spi_cs,
  input  logic       spi_sck,
  input  logic       spi_mosi,
  input  logic       tx_load,
  input  logic [7:0] tx_data,
  output logic       cs_active,
  output logic       cs_fall,
  output logic       byte_done,
  output logic [7:0] rx_byte,
  output logic       spi_miso
);

  logic [2:0] cs_q;
  logic [2:0] sck_q;
  logic [1:0] mosi_q;
  logic [2:0] bit_cnt;
  logic [6:0] rx_shift;
  logic [7:0] tx_shift;
  logic       sck_rise;
  logic       sck_fall;

  // Stages 0/1 synchronise, stage 2 is the previous value for edge detect.
  // MOSI uses the same depth so it lines up with the detected SCK edge.
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      cs_q   <= '0;
      sck_q  <= '0;
      mosi_q <= '0;
    end else begin
      cs_q   <= {cs_q[1:0], spi_cs};
      sck_q  <= {sck_q[1:0], spi_sck};
      mosi_q <= {mosi_q[0], spi_mosi};
    end
  end

  assign cs_active = ~cs_q[1];
  assign cs_fall   = ~cs_q[1] & cs_q[2];
  assign sck_rise  = sck_q[1] & ~sck_q[2];
  assign sck_fall  = ~sck_q[1] & sck_q[2];

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      bit_cnt   <= '0;
      rx_shift  <= '0;
      rx_byte   <= '0;
      byte_done <= 1'b0;
    end else begin
      byte_done <= 1'b0;
      if (!cs_active) begin
        bit_cnt  <= '0;
        rx_shift <= '0;
      end else if (sck_rise) begin
        bit_cnt  <= bit_cnt + 3'd1;
        rx_shift <= {rx_shift[5:0], mosi_q[1]};
        if (bit_cnt == 3'd7) begin
          byte_done <= 1'b1;
          rx_byte   <= {rx_shift, mosi_q[1]};
        end
      end
    end
  end

  // No shift on the fall after the 8th rise (bit_cnt back at 0): the
  // freshly loaded byte must present its MSB for the next rise.
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      tx_shift <= '0;
    end else if (!cs_active) begin
      tx_shift <= '0;
    end else if (tx_load) begin
      tx_shift <= tx_data;
    end else if (sck_fall && bit_cnt != '0) begin
      tx_shift <= {tx_shift[6:0], 1'b0};
    end
  end

  assign spi_miso = cs_active & tx_shift[7];

endmodule

// File: rtl/spi_cfg_regbank.sv
// SPI-programmable bank of NUM_REGS 8-bit configuration registers.
// Command byte: bit7 write/read, bits6:0 start address; following bytes
// access consecutive addresses (wrapping 127 -> 0). Host writes land in a
// shadow copy which is copied to the active copy on each vsync rising edge.
// Build option CFG_IMMEDIATE_EN: no shadow, writes hit the active copy
// directly, cfg_update pulses per write and vsync is ignored.
//   sclk, s_rst_n : system clock, async active-low reset
//   spi           : SPI pins (slave modport)
//   vsync         : asynchronous frame sync
//   cfg_regs      : active register values, reg i at [8i+7:8i]
//   cfg_update    : one-cycle pulse when the active copy reloads
//   cfg_err       : sticky out-of-range access flag
module spi_cfg_regbank
  import cfg_regbank_pkg::*;
#(
  parameter int unsigned               NUM_REGS = 8,
  parameter logic [NUM_REGS*8-1:0]     RST_VALS = {{(NUM_REGS-1){8'h00}}, DEF_THRESH}
) (
  input  logic                  sclk,
  input  logic                  s_rst_n,
  spi_cfg_regbank_if.slave      spi,
  input  logic                  vsync,
  output logic [NUM_REGS*8-1:0] cfg_regs,
  output logic                  cfg_update,
  output logic                  cfg_err
);

  localparam int unsigned       IDX_W     = $clog2(NUM_REGS);
  localparam logic [ADDR_W:0]   REG_LIMIT = (ADDR_W+1)'(NUM_REGS);

  fsm_state_t        state;
  logic              rw;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] addr_next;
  logic              addr_ok;
  logic              cs_active;
  logic              cs_fall;
  logic              byte_done;
  logic [7:0]        rx_byte;
  logic              tx_load;
  logic [7:0]        tx_data;
  logic              wr_en;
  logic [7:0]        active [NUM_REGS];
`ifndef CFG_IMMEDIATE_EN
  logic [7:0]        shadow [NUM_REGS];
  logic [2:0]        vs_q;
  logic              vs_rise;
`else
  logic              vsync_unused;
  assign vsync_unused = vsync;
`endif

  spi_byte_rx_sync u_rx (
    .sclk      (sclk),
    .s_rst_n   (s_rst_n),
    .spi_cs    (spi.spi_cs),
    .spi_sck   (spi.spi_sck),
    .spi_mosi  (spi.spi_mosi),
    .tx_load   (tx_load),
    .tx_data   (tx_data),
    .cs_active (cs_active),
    .cs_fall   (cs_fall),
    .byte_done (byte_done),
    .rx_byte   (rx_byte),
    .spi_miso  (spi.spi_miso)
  );

  assign addr_ok = ({1'b0, addr} < REG_LIMIT);
  assign wr_en   = cs_active && (state == ST_DATA) && byte_done && rw && addr_ok;

  // Next byte to shift out: the command's own address after the command
  // byte, otherwise the following address in the burst.
  always_comb begin
    addr_next = (state == ST_CMD) ? rx_byte[ADDR_W-1:0] : addr + ADDR_W'(1);
    tx_load   = byte_done && ((state == ST_CMD) || (state == ST_DATA));
    tx_data   = '0;
    if ({1'b0, addr_next} < REG_LIMIT) begin
`ifndef CFG_IMMEDIATE_EN
      tx_data = shadow[addr_next[IDX_W-1:0]];
`else
      tx_data = active[addr_next[IDX_W-1:0]];
`endif
    end
  end

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state   <= ST_IDLE;
      rw      <= 1'b0;
      addr    <= '0;
      cfg_err <= 1'b0;
    end else if (!cs_active) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (cs_fall) state <= ST_CMD;
        ST_CMD: begin
          if (byte_done) begin
            rw    <= rx_byte[CMD_WR_BIT];
            addr  <= rx_byte[ADDR_W-1:0];
            state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (byte_done) begin
            addr <= addr_next;
            if (!addr_ok) cfg_err <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifndef CFG_IMMEDIATE_EN
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      vs_q <= '0;
    end else begin
      vs_q <= {vs_q[1:0], vsync};
    end
  end

  assign vs_rise = vs_q[1] & ~vs_q[2];

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) shadow[i] <= RST_VALS[8*i +: 8];
    end else if (wr_en) begin
      shadow[addr[IDX_W-1:0]] <= rx_byte;
    end
  end

  // A write landing on the same edge as vsync is not seen here: the copy
  // samples the shadow before that edge's update.
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) active[i] <= RST_VALS[8*i +: 8];
      cfg_update <= 1'b0;
    end else begin
      cfg_update <= vs_rise;
      if (vs_rise) active <= shadow;
    end
  end
`else
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) active[i] <= RST_VALS[8*i +: 8];
      cfg_update <= 1'b0;
    end else begin
      cfg_update <= wr_en;
      if (wr_en) active[addr[IDX_W-1:0]] <= rx_byte;
    end
  end
`endif

  always_comb begin
    cfg_regs = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) cfg_regs[8*i +: 8] = active[i];
  end

endmodule

// File: tb/tb_spi_cfg_regbank.sv
// Directed bench for spi_cfg_regbank (default frame-synchronous build).
module tb_spi_cfg_regbank;

  localparam int unsigned HALF = 6;

  logic        sclk    = 1'b0;
  logic        s_rst_n = 1'b0;
  logic        vsync   = 1'b0;
  logic [63:0] cfg_regs;
  logic        cfg_update;
  logic        cfg_err;
  logic [7:0]  rx;
  logic [7:0]  dummy;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  spi_cfg_regbank_if spi ();

  spi_cfg_regbank #(.NUM_REGS(8)) dut (
    .sclk       (sclk),
    .s_rst_n    (s_rst_n),
    .spi        (spi),
    .vsync      (vsync),
    .cfg_regs   (cfg_regs),
    .cfg_update (cfg_update),
    .cfg_err    (cfg_err)
  );

  always #5 sclk = ~sclk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge sclk);
    #1;
  endtask

  task automatic cs_begin();
    spi.spi_cs = 1'b0;
    tick(HALF);
  endtask

  task automatic cs_end();
    tick(HALF);
    spi.spi_cs = 1'b1;
    tick(2*HALF);
  endtask

  // Mode-0 transfer of nbits MSB-first; MISO sampled just before each rise.
  // With vs_on_last, vsync rises one sclk after the final SCK rise so that
  // both synchronised edges land in the same cycle.
  task automatic xfer(input logic [7:0] tx, input int unsigned nbits,
                      input bit vs_on_last, output logic [7:0] rx_o);
    rx_o = '0;
    for (int unsigned i = 0; i < nbits; i++) begin
      spi.spi_mosi = tx[7-i];
      tick(HALF);
      rx_o = {rx_o[6:0], spi.spi_miso};
      spi.spi_sck = 1'b1;
      if (vs_on_last && i == nbits - 1) begin
        tick(1);
        vsync = 1'b1;
        tick(HALF - 1);
      end else begin
        tick(HALF);
      end
      spi.spi_sck = 1'b0;
    end
  endtask

  task automatic wr_reg(input logic [6:0] a, input logic [7:0] d);
    cs_begin();
    xfer({1'b1, a}, 8, 1'b0, dummy);
    xfer(d, 8, 1'b0, dummy);
    cs_end();
  endtask

  task automatic vsync_pulse();
    vsync = 1'b1;
    tick(4);
    vsync = 1'b0;
    tick(4);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    spi.spi_cs   = 1'b1;
    spi.spi_sck  = 1'b0;
    spi.spi_mosi = 1'b0;
    tick(3);
    s_rst_n = 1'b1;
    tick(4);

    check_eq("reset_regs",   cfg_regs,   64'h0000_0000_0000_0032);
    check_eq("reset_miso",   spi.spi_miso, 64'd0);
    check_eq("reset_err",    cfg_err,    64'd0);
    check_eq("reset_update", cfg_update, 64'd0);

    // Shadow write, then vsync with 3-cycle latency and single-cycle pulse.
    wr_reg(7'd1, 8'h3C);
    check_eq("pre_vsync_reg1", cfg_regs[15:8], 64'h00);
    vsync = 1'b1;
    tick(2);
    check_eq("lat2_reg1",   cfg_regs[15:8], 64'h00);
    check_eq("lat2_update", cfg_update,     64'd0);
    tick(1);
    check_eq("lat3_reg1",   cfg_regs[15:8], 64'h3C);
    check_eq("lat3_update", cfg_update,     64'd1);
    tick(1);
    check_eq("update_width", cfg_update,    64'd0);
    tick(5);
    check_eq("vsync_held_no_repulse", cfg_update, 64'd0);
    vsync = 1'b0;
    tick(4);

    // Burst write reg0..reg2 then burst readback of the shadow.
    cs_begin();
    xfer(8'h80, 8, 1'b0, dummy);
    xfer(8'h14, 8, 1'b0, dummy);
    xfer(8'h01, 8, 1'b0, dummy);
    xfer(8'h1E, 8, 1'b0, dummy);
    cs_end();
    cs_begin();
    xfer(8'h00, 8, 1'b0, dummy);
    xfer(8'h00, 8, 1'b0, rx);
    check_eq("burst_rd0", rx, 64'h14);
    xfer(8'h00, 8, 1'b0, rx);
    check_eq("burst_rd1", rx, 64'h01);
    xfer(8'h00, 8, 1'b0, rx);
    check_eq("burst_rd2", rx, 64'h1E);
    cs_end();
    check_eq("active_held", cfg_regs, 64'h0000_0000_0000_3C32);

    // Out-of-range write is dropped and flags cfg_err; read returns 0.
    wr_reg(7'd10, 8'hFF);
    check_eq("oor_err", cfg_err, 64'd1);
    cs_begin();
    xfer(8'h0A, 8, 1'b0, dummy);
    xfer(8'h00, 8, 1'b0, rx);
    check_eq("oor_read", rx, 64'h00);
    cs_end();
    vsync_pulse();
    check_eq("regs_after_burst", cfg_regs, 64'h0000_0000_001E_0114);
    check_eq("err_sticky",       cfg_err,  64'd1);

    // CS raised mid data byte: write discarded, next transaction works.
    cs_begin();
    xfer(8'h82, 8, 1'b0, dummy);
    xfer(8'hAA, 4, 1'b0, dummy);
    cs_end();
    check_eq("idle_miso", spi.spi_miso, 64'd0);
    cs_begin();
    xfer(8'h02, 8, 1'b0, dummy);
    xfer(8'h00, 8, 1'b0, rx);
    check_eq("partial_no_write", rx, 64'h1E);
    cs_end();
    wr_reg(7'd4, 8'h77);
    vsync_pulse();
    check_eq("after_partial", cfg_regs, 64'h0000_0077_001E_0114);

    // Write commit and vsync rise in the same cycle.
    cs_begin();
    xfer(8'h83, 8, 1'b0, dummy);
    xfer(8'h5A, 8, 1'b1, dummy);
    cs_end();
    check_eq("same_cycle_old", cfg_regs, 64'h0000_0077_001E_0114);
    vsync = 1'b0;
    tick(4);
    vsync_pulse();
    check_eq("same_cycle_next", cfg_regs, 64'h0000_0077_5A1E_0114);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
